// File: rtl/vector_instr_sequencer.sv
// Instruction replay engine for vector_processor: buffers a short host program,
// issues each entry for HOLD_CYCLES cycles and captures results of store instructions.
module vector_instr_sequencer #(
    parameter int          INSTR_W     = 13,
    parameter int          DATA_W      = 512,
    parameter int          DEPTH       = 16,
    parameter int          HOLD_CYCLES = 2,
    parameter logic [3:0]  STORE_OP    = 4'b0110
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [INSTR_W-1:0]       load_instr,
    input  logic                     start,
    input  logic                     abort,
    output logic [INSTR_W-1:0]       instruction_set,
    output logic                     issue_strobe,
    input  logic [DATA_W-1:0]        mem_written,
    output logic [DATA_W-1:0]        capture_data,
    output logic                     capture_valid,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW  = $clog2(DEPTH);
    localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [AW:0]    FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

    typedef enum logic {IDLE, HOLD} state_e;

    state_e               state_q, state_d;
    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [HCW-1:0]       hold_cnt_q, hold_cnt_d;
    logic [INSTR_W-1:0]   instruction_set_q, instruction_set_d;
    logic                 issue_strobe_q, issue_strobe_d;
    logic [DATA_W-1:0]    capture_data_q, capture_data_d;
    logic                 capture_valid_q, capture_valid_d;
    logic                 done_q, done_d;

    logic [INSTR_W-1:0]   instr_buf_q [DEPTH];

    logic                 load_accept;
    logic                 more_instr;
    logic [AW-1:0]        rd_next;

    assign load_ready  = (state_q == IDLE) && (wr_ptr_q < FULL_CNT);
    assign load_accept = load_valid && load_ready && !abort;
    assign rd_next     = rd_ptr_q + AW'(1);
    // Compared one bit wider so a completely full buffer is recognised as finished.
    assign more_instr  = ({1'b0, rd_ptr_q} + (AW+1)'(1)) < wr_ptr_q;

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned; that is what keeps this block from inferring latches.
    always_comb begin
        state_d           = state_q;
        wr_ptr_d          = wr_ptr_q;
        rd_ptr_d          = rd_ptr_q;
        hold_cnt_d        = hold_cnt_q;
        instruction_set_d = instruction_set_q;
        capture_data_d    = capture_data_q;
        issue_strobe_d    = 1'b0;
        capture_valid_d   = 1'b0;
        done_d            = 1'b0;

        if (abort) begin
            state_d           = IDLE;
            instruction_set_d = '0;
            wr_ptr_d          = '0;
            rd_ptr_d          = '0;
            hold_cnt_d        = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_accept) begin
                        wr_ptr_d = wr_ptr_q + (AW+1)'(1);
                    end
                    if (start && (wr_ptr_q != '0)) begin
                        instruction_set_d = instr_buf_q[0];
                        issue_strobe_d    = 1'b1;
                        hold_cnt_d        = HOLD_LAST;
                        rd_ptr_d          = '0;
                        state_d           = HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt_q != '0) begin
                        hold_cnt_d = hold_cnt_q - HCW'(1);
                    end else begin
                        if (instruction_set_q[INSTR_W-1 -: 4] == STORE_OP) begin
                            capture_data_d  = mem_written;
                            capture_valid_d = 1'b1;
                        end
                        if (more_instr) begin
                            rd_ptr_d          = rd_next;
                            instruction_set_d = instr_buf_q[rd_next];
                            issue_strobe_d    = 1'b1;
                            hold_cnt_d        = HOLD_LAST;
                        end else begin
                            instruction_set_d = '0;
                            done_d            = 1'b1;
                            wr_ptr_d          = '0;
                            rd_ptr_d          = '0;
                            state_d           = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q           <= IDLE;
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            hold_cnt_q        <= '0;
            instruction_set_q <= '0;
            issue_strobe_q    <= 1'b0;
            capture_data_q    <= '0;
            capture_valid_q   <= 1'b0;
            done_q            <= 1'b0;
        end else begin
            state_q           <= state_d;
            wr_ptr_q          <= wr_ptr_d;
            rd_ptr_q          <= rd_ptr_d;
            hold_cnt_q        <= hold_cnt_d;
            instruction_set_q <= instruction_set_d;
            issue_strobe_q    <= issue_strobe_d;
            capture_data_q    <= capture_data_d;
            capture_valid_q   <= capture_valid_d;
            done_q            <= done_d;
        end
    end

    // NOTE: the buffer has no reset; entries are only read below wr_ptr, which
    // is reset, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (load_accept) begin
            instr_buf_q[wr_ptr_q[AW-1:0]] <= load_instr;
        end
    end

    assign instruction_set = instruction_set_q;
    assign issue_strobe    = issue_strobe_q;
    assign capture_data    = capture_data_q;
    assign capture_valid   = capture_valid_q;
    assign done            = done_q;
    assign busy            = (state_q == HOLD);
    assign count           = wr_ptr_q;

endmodule

// File: doc/vector_instr_sequencer.md
Name: vector_instr_sequencer

Overview:
- Host-side command issuer for vector_processor. It drives the processor's 13-bit instruction_set input and samples its 512-bit mem_written result.
- A host preloads a short program into an internal instruction buffer, then pulses start. The block replays the program one instruction at a time, holding each for a fixed number of cycles.
- Store results are captured and presented to the host with a valid pulse.
- It sits between the host/testbench and vector_processor, in place of hand-driven command sequences.

Parameters:
- INSTR_W, 13, instruction width; matches vector_processor instruction_set.
- DATA_W, 512, width of mem_written and capture_data.
- DEPTH, 16, instruction buffer entries; power of two, at least 2.
- HOLD_CYCLES, 2, cycles each instruction stays on instruction_set; at least 1.
- STORE_OP, 4'b0110, value of instruction bits [12:9] that marks a store-to-memory instruction.

Ports:
- clk, input, 1, system clock; all state changes on its rising edge.
- reset, input, 1, asynchronous, active-low reset.
- load_valid, input, 1, host offers load_instr.
- load_ready, output, 1, buffer can accept an entry.
- load_instr, input, INSTR_W, instruction to append to the buffer.
- start, input, 1, begin replaying the buffered program.
- abort, input, 1, stop immediately and clear the buffer.
- instruction_set, output, INSTR_W, command to vector_processor; 0 means idle/NOP.
- issue_strobe, output, 1, high in the first cycle each new instruction appears.
- mem_written, input, DATA_W, result bus from vector_processor.
- capture_data, output, DATA_W, mem_written sampled for the latest store.
- capture_valid, output, 1, one-cycle pulse when capture_data updates.
- busy, output, 1, high while in HOLD.
- done, output, 1, one-cycle pulse when the program completes.
- count, output, log2(DEPTH)+1, number of entries currently loaded.

Behaviour:
- Reset while low, from any state:
  - state=IDLE; wr_ptr, rd_ptr, hold_cnt all 0.
  - instruction_set, issue_strobe, capture_data, capture_valid, busy, done all 0.
  - Buffer contents are don't-care.
- load_ready = (state==IDLE) && (wr_ptr<DEPTH). This is combinational.
  - A load is accepted on an edge where load_valid && load_ready: buf[wr_ptr]<=load_instr, wr_ptr++.
  - count = wr_ptr.
  - A load offered while full or busy is not accepted and has no effect.
- States: IDLE, HOLD.
- IDLE, start=1 and wr_ptr>0, at that edge:
  - instruction_set<=buf[0], issue_strobe<=1, hold_cnt<=HOLD_CYCLES-1, rd_ptr<=0, state<=HOLD.
  - First instruction is visible the cycle after start is sampled; latency 1.
- IDLE, start=1 and wr_ptr==0: start is ignored and no done pulse is generated.
- HOLD: busy=1 and issue_strobe<=0 by default.
  - If hold_cnt>0: hold_cnt--, instruction_set unchanged.
  - If hold_cnt==0 (last hold cycle), three things happen at that edge:
    - Capture: if instruction_set[12:9]==STORE_OP, capture_data<=mem_written and capture_valid<=1 for one cycle.
    - More instructions (rd_ptr+1<wr_ptr): rd_ptr++, instruction_set<=buf[rd_ptr+1], issue_strobe<=1, hold_cnt<=HOLD_CYCLES-1. Instructions run back-to-back with no gap.
    - Last instruction: instruction_set<=0, done<=1 for one cycle, wr_ptr<=0, rd_ptr<=0, state<=IDLE.
- HOLD_CYCLES=1: a new instruction appears every cycle and issue_strobe stays high continuously.
- start while in HOLD is ignored.
- abort (synchronous, highest priority after reset), from any state:
  - state<=IDLE, instruction_set<=0, wr_ptr<=0, rd_ptr<=0, issue_strobe<=0.
  - No done pulse and no capture on the abort edge.
- abort and load on the same edge: abort wins and the load is dropped.
- Buffer full (wr_ptr==DEPTH): load_ready=0. start still runs all DEPTH entries; rd_ptr never wraps.
- capture_data holds its value until the next store capture or reset. It is not cleared by abort or done.

Test Plan:
- Reset: assert reset=0 mid-HOLD with instruction_set=13'b0110000000000 -> next sample shows all outputs 0, count=0, load_ready=1.
- Single store: load 13'b0110000000000, pulse start, mem_written=512'hA5 repeated, HOLD_CYCLES=2:
  - instruction_set=0x0C00 for exactly 2 cycles, issue_strobe high only in the first.
  - capture_valid pulses once with capture_data equal to mem_written.
  - done pulses in the cycle instruction_set returns to 0.
- Sequence of 3 (non-store, store, non-store) -> three back-to-back 2-cycle windows, 3 issue_strobe pulses, exactly one capture_valid (during the store), done after 6 busy cycles.
- Fill: offer 17 loads at DEPTH=16 -> first 16 accepted, count=16, load_ready=0; 17th dropped; run issues exactly 16 instructions.
- Start with empty buffer -> no issue_strobe, no done, state stays IDLE.
- Abort during the 2nd of 3 instructions -> instruction_set=0 next cycle, no done, count=0; a following start does nothing until new loads are made.
